// File: rtl/keypad_calc_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_calc_if
// Purpose  : Key-event inputs and calculator display outputs of keypad_calc_fsm.
// Revision : 1.0  initial release
// ============================================================================
interface keypad_calc_if #(
  parameter int VAL_W = 14
);
  logic             key_valid;
  logic [511:0]     key_down;
  logic [7:0]       last_change;
  logic [VAL_W-1:0] opa;
  logic [VAL_W-1:0] opb;
  logic [2:0]       digit_cnt;
  logic [1:0]       op;
  logic             sign;
  logic [VAL_W-1:0] value;
  logic             result_valid;
  logic [1:0]       state;

  modport master (
    output key_valid, key_down, last_change,
    input  opa, opb, digit_cnt, op, sign, value, result_valid, state
  );

  modport slave (
    input  key_valid, key_down, last_change,
    output opa, opb, digit_cnt, op, sign, value, result_valid, state
  );
endinterface
`default_nettype wire

// File: rtl/keypad_calc_fsm.sv
`default_nettype none
// ============================================================================
// Module   : keypad_calc_fsm
// Purpose  : Keypad integer calculator (+,-,*) with multi-digit operand entry.
// Revision : 1.0  initial release
// ============================================================================
module keypad_calc_fsm #(
  parameter int DIGITS = 2,
  parameter int VAL_W  = 14
) (
  input  wire          clk,
  input  wire          rst,
  keypad_calc_if.slave bus
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_RES = 2'd2
  } state_t;

  localparam logic [VAL_W-1:0] c_TEN    = VAL_W'(10);
  localparam logic [2:0]       c_DIGITS = 3'(DIGITS);

  state_t           r_state;
  logic [VAL_W-1:0] r_opa;
  logic [VAL_W-1:0] r_opb;
  logic [2:0]       r_cnt;
  logic [1:0]       r_op;
  logic             r_sign;
  logic [VAL_W-1:0] r_value;
  logic             r_result_valid;

  logic             w_ev;
  logic             w_is_digit;
  logic [3:0]       w_digit;
  logic [1:0]       w_op_code;
  logic             w_is_enter;
  logic             w_is_esc;
  logic             w_is_bksp;
  logic [VAL_W-1:0] w_cur;
  logic [VAL_W-1:0] w_push;
  logic [VAL_W-1:0] w_pop;
  logic [VAL_W-1:0] w_calc;
  logic             w_calc_neg;

  assign w_ev = bus.key_valid & bus.key_down[{1'b0, bus.last_change}];

  always_comb begin
    w_is_digit = 1'b1;
    w_digit    = 4'd0;
    w_op_code  = 2'd0;
    w_is_enter = 1'b0;
    w_is_esc   = 1'b0;
    w_is_bksp  = 1'b0;
    case (bus.last_change)
      8'h70: w_digit = 4'd0;
      8'h69: w_digit = 4'd1;
      8'h72: w_digit = 4'd2;
      8'h7A: w_digit = 4'd3;
      8'h6B: w_digit = 4'd4;
      8'h73: w_digit = 4'd5;
      8'h74: w_digit = 4'd6;
      8'h6C: w_digit = 4'd7;
      8'h75: w_digit = 4'd8;
      8'h7D: w_digit = 4'd9;
      default: begin
        w_is_digit = 1'b0;
        case (bus.last_change)
          8'h79:   w_op_code  = 2'd1;
          8'h7B:   w_op_code  = 2'd2;
          8'h7C:   w_op_code  = 2'd3;
          8'h5A:   w_is_enter = 1'b1;
          8'h76:   w_is_esc   = 1'b1;
          8'h66:   w_is_bksp  = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

  // Digit/backspace edits apply to whichever operand is currently being entered.
  assign w_cur  = (r_state == S_B) ? r_opb : r_opa;
  assign w_push = w_cur * c_TEN + {{(VAL_W-4){1'b0}}, w_digit};
  assign w_pop  = w_cur / c_TEN;

  always_comb begin
    w_calc     = r_opa + r_opb;
    w_calc_neg = 1'b0;
    case (r_op)
      2'd2: begin
        if (r_opa < r_opb) begin
          w_calc     = r_opb - r_opa;
          w_calc_neg = 1'b1;
        end else begin
          w_calc     = r_opa - r_opb;
        end
      end
      2'd3:    w_calc = r_opa * r_opb;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_A;
      r_opa          <= '0;
      r_opb          <= '0;
      r_cnt          <= 3'd0;
      r_op           <= 2'd0;
      r_sign         <= 1'b0;
      r_value        <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      if (w_ev) begin
        if (w_is_esc) begin
          r_state <= S_A;
          r_opa   <= '0;
          r_opb   <= '0;
          r_cnt   <= 3'd0;
          r_op    <= 2'd0;
          r_sign  <= 1'b0;
          r_value <= '0;
        end else begin
          case (r_state)
            S_A: begin
              if (w_is_digit && r_cnt < c_DIGITS) begin
                r_opa <= w_push;
                r_cnt <= r_cnt + 3'd1;
              end else if (w_is_bksp && r_cnt != 3'd0) begin
                r_opa <= w_pop;
                r_cnt <= r_cnt - 3'd1;
              end else if (w_op_code != 2'd0 && r_cnt != 3'd0) begin
                r_op    <= w_op_code;
                r_cnt   <= 3'd0;
                r_state <= S_B;
              end
            end
            S_B: begin
              if (w_is_digit && r_cnt < c_DIGITS) begin
                r_opb <= w_push;
                r_cnt <= r_cnt + 3'd1;
              end else if (w_is_bksp && r_cnt != 3'd0) begin
                r_opb <= w_pop;
                r_cnt <= r_cnt - 3'd1;
              end else if (w_op_code != 2'd0) begin
                r_op <= w_op_code;
              end else if (w_is_enter && r_cnt != 3'd0) begin
                r_value        <= w_calc;
                r_sign         <= w_calc_neg;
                r_result_valid <= 1'b1;
                r_state        <= S_RES;
              end
            end
            S_RES: begin
              if (w_is_digit) begin
                r_opa   <= {{(VAL_W-4){1'b0}}, w_digit};
                r_opb   <= '0;
                r_op    <= 2'd0;
                r_sign  <= 1'b0;
                r_value <= '0;
                r_cnt   <= 3'd1;
                r_state <= S_A;
              end else if (w_op_code != 2'd0 && !r_sign) begin
                // A negative magnitude cannot seed a new unsigned operand.
                r_opa   <= r_value;
                r_opb   <= '0;
                r_cnt   <= 3'd0;
                r_op    <= w_op_code;
                r_state <= S_B;
              end
            end
            default: r_state <= S_A;
          endcase
        end
      end
    end
  end

  assign bus.opa          = r_opa;
  assign bus.opb          = r_opb;
  assign bus.digit_cnt    = r_cnt;
  assign bus.op           = r_op;
  assign bus.sign         = r_sign;
  assign bus.value        = r_value;
  assign bus.result_valid = r_result_valid;
  assign bus.state        = r_state;

endmodule
`default_nettype wire
